// File: rtl/mtimer_defs.sv
// Shared definitions for the machine timer block: register offsets,
// CTRL field positions and the CSR address list used by the core.
package mtimer_defs;

   localparam int OFS_MTIME_LO    = 0;
   localparam int OFS_MTIME_HI    = 1;
   localparam int OFS_MTIMECMP_LO = 2;
   localparam int OFS_MTIMECMP_HI = 3;
   localparam int OFS_CTRL        = 4;

   localparam int CTRL_EN_BIT  = 0;
   localparam int CTRL_DIV_LSB = 8;

   localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MIP     = 12'h344;
   localparam logic [11:0] CSR_TIME    = 12'hC01;
   localparam logic [11:0] CSR_TIMEH   = 12'hC81;

   localparam int MIP_MTIP_BIT = 7;

endpackage

// File: rtl/mtimer_prescaler.sv
// Tick generator: count runs 0..div, tick in the cycle count equals div.
// Held at zero while disabled or when cleared by a CTRL write.
module mtimer_prescaler #(
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               resetb,
   input  logic               en,
   input  logic [PRESC_W-1:0] div,
   input  logic               clr,
   output logic               tick
);

   logic [PRESC_W-1:0] cnt_q;

   assign tick = en & (cnt_q == div);

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         cnt_q <= '0;
      end else if (clr | ~en | tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + PRESC_W'(1);
      end
   end

endmodule

// File: rtl/mtimer.sv
// Memory-mapped 64-bit machine timer with prescaler, compare interrupt
// and a latched high word for tear-free reads.
module mtimer
   import mtimer_defs::*;
#(
   parameter int BASE_W  = 3,
   parameter int PRESC_W = 8
) (
   input  logic              clk,
   input  logic              resetb,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [BASE_W-1:0] mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic [31:0]       mem_rdata,
   output logic              mem_ready,
   output logic              irq_mtimecmp
);

   logic [63:0]        mtime_q, mtime_d;
   logic [63:0]        cmp_q, cmp_d;
   logic               en_q, en_d;
   logic [PRESC_W-1:0] div_q, div_d;
   logic [31:0]        shadow_q, shadow_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               ready_q;
   logic               irq_q;
   logic               tick;
   logic [31:0]        ctrl_rdata;

   logic rd, wr;
   logic sel_lo, sel_hi, sel_clo, sel_chi, sel_ctrl;

   assign rd = mem_req & ~mem_we;
   assign wr = mem_req & mem_we;

   assign sel_lo   = mem_addr == BASE_W'(OFS_MTIME_LO);
   assign sel_hi   = mem_addr == BASE_W'(OFS_MTIME_HI);
   assign sel_clo  = mem_addr == BASE_W'(OFS_MTIMECMP_LO);
   assign sel_chi  = mem_addr == BASE_W'(OFS_MTIMECMP_HI);
   assign sel_ctrl = mem_addr == BASE_W'(OFS_CTRL);

   mtimer_prescaler #(
      .PRESC_W (PRESC_W)
   ) u_presc (
      .clk    (clk),
      .resetb (resetb),
      .en     (en_q),
      .div    (div_q),
      .clr    (wr & sel_ctrl),
      .tick   (tick)
   );

   always_comb begin
      ctrl_rdata = '0;
      ctrl_rdata[CTRL_EN_BIT] = en_q;
      ctrl_rdata[CTRL_DIV_LSB +: PRESC_W] = div_q;
   end

   always_comb begin
      rdata_d = '0;
      if (rd) begin
         unique case (1'b1)
            sel_lo:   rdata_d = mtime_q[31:0];
            sel_hi:   rdata_d = shadow_q;
            sel_clo:  rdata_d = cmp_q[31:0];
            sel_chi:  rdata_d = cmp_q[63:32];
            sel_ctrl: rdata_d = ctrl_rdata;
            default:  rdata_d = '0;
         endcase
      end
   end

   // A bus write to either half wins over the tick; no carry survives.
   always_comb begin
      mtime_d  = mtime_q;
      cmp_d    = cmp_q;
      en_d     = en_q;
      div_d    = div_q;
      shadow_d = shadow_q;
      if (wr & sel_lo) begin
         mtime_d[31:0] = mem_wdata;
      end else if (wr & sel_hi) begin
         mtime_d[63:32] = mem_wdata;
      end else if (tick) begin
         mtime_d = mtime_q + 64'd1;
      end
      if (wr & sel_clo) cmp_d[31:0] = mem_wdata;
      if (wr & sel_chi) cmp_d[63:32] = mem_wdata;
      if (wr & sel_ctrl) begin
         en_d  = mem_wdata[CTRL_EN_BIT];
         div_d = mem_wdata[CTRL_DIV_LSB +: PRESC_W];
      end
      if (rd & sel_lo) shadow_d = mtime_q[63:32];
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         mtime_q  <= '0;
         cmp_q    <= MTIMECMP_RST;
         en_q     <= 1'b0;
         div_q    <= '0;
         shadow_q <= '0;
         rdata_q  <= '0;
         ready_q  <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         mtime_q  <= mtime_d;
         cmp_q    <= cmp_d;
         en_q     <= en_d;
         div_q    <= div_d;
         shadow_q <= shadow_d;
         rdata_q  <= rdata_d;
         ready_q  <= mem_req;
         irq_q    <= mtime_d >= cmp_d;
      end
   end

   assign mem_rdata    = rdata_q;
   assign mem_ready    = ready_q;
   assign irq_mtimecmp = irq_q;

endmodule

// File: tb/tb_mtimer.sv
// Bench for mtimer: cycle model of the timer's rules checked every
// cycle, plus directed accesses with literal expectations.
module tb_mtimer;

   logic        clk;
   logic        resetb;
   logic        mem_req;
   logic        mem_we;
   logic [2:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        irq_mtimecmp;

   int errs;
   int checks;
   bit chk_on;

   logic [63:0] m_time, m_cmp;
   bit          m_en;
   int          m_div, m_cnt;
   logic [31:0] m_shadow;
   logic        exp_ready, exp_irq;
   logic [31:0] exp_rdata;

   mtimer #(
      .BASE_W  (3),
      .PRESC_W (8)
   ) dut (
      .clk          (clk),
      .resetb       (resetb),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready),
      .irq_mtimecmp (irq_mtimecmp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(string n, logic [63:0] got,
                                 logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
      end
   endfunction

   always @(negedge clk) begin
      if (chk_on) begin
         check("ready", mem_ready, exp_ready);
         check("rdata", mem_rdata, exp_rdata);
         check("irq", irq_mtimecmp, exp_irq);
      end
   end

   task automatic model_reset();
      m_time    = 64'd0;
      m_cmp     = 64'hFFFF_FFFF_FFFF_FFFF;
      m_en      = 1'b0;
      m_div     = 0;
      m_cnt     = 0;
      m_shadow  = 32'd0;
      exp_ready = 1'b0;
      exp_rdata = 32'd0;
      exp_irq   = 1'b0;
   endtask

   function automatic logic [31:0] reg_value(int a);
      case (a)
         0: return m_time[31:0];
         1: return m_shadow;
         2: return m_cmp[31:0];
         3: return m_cmp[63:32];
         4: return 32'(m_en) | (32'(m_div) << 8);
         default: return 32'd0;
      endcase
   endfunction

   // One clock: model computes the next state from the applied inputs.
   task automatic cyc();
      bit          tk, rq, we;
      int          a;
      logic [63:0] nt, nc;
      logic [31:0] rv, sh;
      bit          ne;
      int          nd, ncnt;
      rq = mem_req;
      we = mem_we;
      a  = int'(mem_addr);
      tk = m_en && (m_cnt == m_div);
      rv = reg_value(a);
      nt = m_time;
      nc = m_cmp;
      ne = m_en;
      nd = m_div;
      sh = m_shadow;
      ncnt = (tk || !m_en) ? 0 : m_cnt + 1;
      if (rq && we && a == 0)      nt = {m_time[63:32], mem_wdata};
      else if (rq && we && a == 1) nt = {mem_wdata, m_time[31:0]};
      else if (tk)                 nt = m_time + 64'd1;
      if (rq && we && a == 2) nc[31:0] = mem_wdata;
      if (rq && we && a == 3) nc[63:32] = mem_wdata;
      if (rq && we && a == 4) begin
         ne   = mem_wdata[0];
         nd   = int'(mem_wdata[15:8]);
         ncnt = 0;
      end
      if (rq && !we && a == 0) sh = m_time[63:32];
      @(posedge clk);
      m_time    = nt;
      m_cmp     = nc;
      m_en      = ne;
      m_div     = nd;
      m_cnt     = ncnt;
      m_shadow  = sh;
      exp_ready = rq;
      exp_rdata = (rq && !we) ? rv : 32'd0;
      exp_irq   = nt >= nc;
      #1;
   endtask

   task automatic acc(input bit we, input int a, input logic [31:0] wd,
                      output logic [31:0] rd);
      mem_req   = 1'b1;
      mem_we    = we;
      mem_addr  = 3'(a);
      mem_wdata = wd;
      cyc();
      rd = mem_rdata;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = 32'd0;
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      logic [31:0] dummy;
      acc(1'b1, a, d, dummy);
   endtask

   task automatic rdr(input int a, output logic [31:0] v);
      acc(1'b0, a, 32'd0, v);
   endtask

   task automatic do_reset();
      resetb = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 resetb = 1'b1;
   endtask

   initial begin
      logic [31:0] v;
      logic [31:0] lo;
      int n;
      errs = 0;
      checks = 0;
      chk_on = 1'b0;
      mem_req = 1'b0;
      mem_we = 1'b0;
      mem_addr = 3'd0;
      mem_wdata = 32'd0;
      resetb = 1'b0;
      model_reset();
      chk_on = 1'b1;
      repeat (2) @(posedge clk);
      #1 resetb = 1'b1;

      rdr(4, v); check("ctrl_rst", v, 32'h0);
      rdr(2, v); check("cmplo_rst", v, 32'hFFFF_FFFF);
      rdr(3, v); check("cmphi_rst", v, 32'hFFFF_FFFF);
      check("irq_rst", irq_mtimecmp, 1'b0);

      wr(4, 32'h0000_0301);
      repeat (40) cyc();
      rdr(0, v); check("div3_lo", v, 32'd10);
      rdr(1, v); check("div3_hi", v, 32'd0);

      wr(4, 32'h0);
      wr(1, 32'h0);
      wr(0, 32'hFFFF_FFFE);
      wr(4, 32'h1);
      repeat (3) cyc();
      rdr(0, v); check("wrap_lo", v, 32'd1);
      rdr(1, v); check("wrap_hi", v, 32'd1);

      wr(4, 32'h0);
      wr(1, 32'h0);
      wr(0, 32'h50);
      wr(4, 32'h1);
      wr(3, 32'h0);
      lo = m_time[31:0] + 32'd5;
      wr(2, lo);
      n = 0;
      while (!irq_mtimecmp && n < 20) begin
         cyc();
         n++;
      end
      check("irq_lat", n, 4);
      rdr(0, v); check("irq_time", v, lo);
      wr(3, 32'hFFFF_FFFF);
      check("irq_drop", irq_mtimecmp, 1'b0);

      wr(0, 32'h100);
      cyc();
      cyc();
      rdr(0, v); check("wrtick_lo", v, 32'h102);
      rdr(1, v); check("wrtick_hi", v, 32'h0);

      wr(4, 32'h0);
      wr(1, 32'h0);
      wr(0, 32'hFFFF_FFFF);
      wr(4, 32'h1);
      wr(0, 32'h5);
      wr(4, 32'h0);
      rdr(0, v); check("nocarry_lo", v, 32'h6);
      rdr(1, v); check("nocarry_hi", v, 32'h0);

      wr(5, 32'hDEAD_BEEF);
      rdr(5, v); check("rsv5", v, 32'h0);
      rdr(6, v); check("rsv6", v, 32'h0);
      rdr(7, v); check("rsv7", v, 32'h0);

      wr(4, 32'h0000_0201);
      repeat (5) cyc();
      mem_req  = 1'b1;
      mem_we   = 1'b0;
      mem_addr = 3'd0;
      cyc();
      mem_req  = 1'b0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("ready_after_rst", mem_ready, 1'b0);
      end
      rdr(4, v); check("ctrl_rst2", v, 32'h0);
      rdr(2, v); check("cmplo_rst2", v, 32'hFFFF_FFFF);
      rdr(3, v); check("cmphi_rst2", v, 32'hFFFF_FFFF);
      rdr(0, v); check("lo_rst2", v, 32'h0);
      rdr(1, v); check("hi_rst2", v, 32'h0);
      cyc();

      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
